// File: rtl/fetch_pkg.sv
// Shared constants and the fetch queue entry layout for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam int unsigned PC_INCR           = INSTR_BYTES;
    localparam int unsigned ENTRY_ADDR_WIDTH  = 32;
    localparam int unsigned ENTRY_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_WIDTH-1:0]  pc;
        logic [ENTRY_INSTR_WIDTH-1:0] instr;
        logic                         filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry in-order fetch queue: entries are allocated at request time,
// filled by responses in order, and popped from the head by decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_WIDTH  = ENTRY_ADDR_WIDTH,
    parameter int unsigned INSTR_WIDTH = ENTRY_INSTR_WIDTH,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   alloc_en,
    input  logic [ADDR_WIDTH-1:0]  alloc_pc,
    input  logic                   fill_en,
    input  logic [INSTR_WIDTH-1:0] fill_instr,
    input  logic                   pop_en,
    output logic [CNT_W-1:0]       count,
    output logic                   fill_ok,
    output logic                   head_valid,
    output logic [ADDR_WIDTH-1:0]  head_pc,
    output logic [INSTR_WIDTH-1:0] head_instr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] alloc_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] head_ptr;

    // fill==alloc is ambiguous only when full; the fill entry's flag disambiguates
    assign fill_ok    = (fill_ptr != alloc_ptr) ||
                        ((count == CNT_W'(DEPTH)) && !entries[fill_ptr].filled);
    assign head_valid = (count != '0) && entries[head_ptr].filled;
    assign head_pc    = ADDR_WIDTH'(entries[head_ptr].pc);
    assign head_instr = INSTR_WIDTH'(entries[head_ptr].instr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i].filled <= 1'b0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            count     <= '0;
        end else begin
            if (alloc_en) begin
                entries[alloc_ptr] <= '{pc: ENTRY_ADDR_WIDTH'(alloc_pc), instr: '0, filled: 1'b0};
                alloc_ptr          <= alloc_ptr + PTR_W'(1);
            end
            if (fill_en) begin
                entries[fill_ptr].instr  <= ENTRY_INSTR_WIDTH'(fill_instr);
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(alloc_en) - CNT_W'(pop_en);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited memory
// requests, redirect flush with discard of responses from abandoned streams.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = ENTRY_ADDR_WIDTH,
    parameter int unsigned          INSTR_WIDTH = ENTRY_INSTR_WIDTH,
    parameter int unsigned          DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      drop_cnt;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      inflight_nxt;
    logic [SUM_W-1:0]      credit_used;
    logic                  req_fire;
    logic                  fill_en;
    logic                  fill_ok;
    logic                  pop;
    logic                  redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // queue entries plus responses still owed to dead streams share DEPTH credits
    assign credit_used    = SUM_W'(count) + SUM_W'(drop_cnt);
    assign imem_req_valid = reset && (credit_used < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fill_en        = imem_rsp_valid && (drop_cnt == '0);
    assign pop            = out_valid && out_ready;
    assign inflight_nxt   = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    fetch_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .alloc_en  (req_fire),
        .alloc_pc  (fetch_pc),
        .fill_en   (fill_en),
        .fill_instr(imem_rsp_data),
        .pop_en    (pop),
        .count     (count),
        .fill_ok   (fill_ok),
        .head_valid(out_valid),
        .head_pc   (out_pc),
        .head_instr(out_instr)
    );

    // on redirect every unanswered request, including this cycle's, becomes a drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
            drop_cnt <= '0;
            inflight <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                drop_cnt <= inflight_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INCR);
                end
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    rsp_has_slot: assert property (@(posedge clk) disable iff (!reset)
        (imem_rsp_valid && (drop_cnt == '0)) |-> fill_ok);

    credit_bound: assert property (@(posedge clk) disable iff (!reset)
        credit_used <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order fixed-latency memory model.
module tb_instr_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int latency = 1;

    logic [AW-1:0] mem_addr[$];
    int            mem_due[$];
    logic [AW-1:0] fired[$];
    logic [AW-1:0] popped_pc[$];
    logic [IW-1:0] popped_instr[$];

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
        return IW'(pc) ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model and transfer log; a response set here is consumed at the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            mem_addr.delete();
            mem_due.delete();
            fired.delete();
            popped_pc.delete();
            popped_instr.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                fired.push_back(imem_req_addr);
                mem_addr.push_back(imem_req_addr);
                mem_due.push_back(cyc + latency);
            end
            if (out_valid && out_ready) begin
                popped_pc.push_back(out_pc);
                popped_instr.push_back(out_instr);
            end
            imem_rsp_valid = 1'b0;
            if (mem_due.size() > 0 && mem_due[0] == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(mem_addr[0]);
                void'(mem_addr.pop_front());
                void'(mem_due.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        latency        = lat;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        step(2);
        sample();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_valid got=%b expected=0", imem_req_valid);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b expected=0", out_valid);
        end
        checks++;
        if (out_pc !== '0) begin
            failures++;
            $display("FAIL reset_out_pc got=%h expected=0", out_pc);
        end
        checks++;
        if (out_instr !== '0) begin
            failures++;
            $display("FAIL reset_out_instr got=%h expected=0", out_instr);
        end
    endtask

    task automatic test_stream();
        logic          exp_ov;
        logic [AW-1:0] exp_pc;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            sample();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== AW'(4 * k)) begin
                failures++;
                $display("FAIL stream_req k=%0d got valid=%b addr=%h expected valid=1 addr=%h",
                         k, imem_req_valid, imem_req_addr, AW'(4 * k));
            end
            exp_ov = (k >= 2);
            checks++;
            if (out_valid !== exp_ov) begin
                failures++;
                $display("FAIL stream_out_valid k=%0d got=%b expected=%b", k, out_valid, exp_ov);
            end
            if (k >= 2) begin
                exp_pc = AW'(4 * (k - 2));
                checks++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    failures++;
                    $display("FAIL stream_out k=%0d got pc=%h instr=%h expected pc=%h instr=%h",
                             k, out_pc, out_instr, exp_pc, instr_of(exp_pc));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        do_reset(1);
        step(8);
        sample();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_req_stalled got=%b expected=0", imem_req_valid);
        end
        checks++;
        if (fired.size() != 4) begin
            failures++;
            $display("FAIL bp_fire_count got=%0d expected=4", fired.size());
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_head got valid=%b pc=%h expected valid=1 pc=0", out_valid, out_pc);
        end
        step(1);
        out_ready = 1'b1;
        step(10);
        sample();
        checks++;
        if (popped_pc.size() < 5 || fired.size() < 5) begin
            failures++;
            $display("FAIL bp_resume_size got pops=%0d fires=%0d expected at least 5 each",
                     popped_pc.size(), fired.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (popped_pc[i] !== AW'(4 * i)) begin
                    failures++;
                    $display("FAIL bp_pop_order i=%0d got=%h expected=%h", i, popped_pc[i], AW'(4 * i));
                end
            end
            checks++;
            if (fired[4] !== 32'h10) begin
                failures++;
                $display("FAIL bp_resume_addr got=%h expected=00000010", fired[4]);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        do_reset(3);
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step(1);
        redirect_valid = 1'b0;
        sample();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            failures++;
            $display("FAIL redir_next_req got valid=%b addr=%h expected valid=1 addr=00000100",
                     imem_req_valid, imem_req_addr);
        end
        step(10);
        sample();
        checks++;
        if (fired.size() < 5 || popped_pc.size() < 2) begin
            failures++;
            $display("FAIL redir_size got fires=%0d pops=%0d expected >=5 and >=2",
                     fired.size(), popped_pc.size());
        end else begin
            checks++;
            if (fired[3] !== 32'hC || fired[4] !== 32'h100) begin
                failures++;
                $display("FAIL redir_fires got=%h,%h expected=0000000c,00000100", fired[3], fired[4]);
            end
            checks++;
            if (popped_pc[0] !== 32'h100 || popped_pc[1] !== 32'h104) begin
                failures++;
                $display("FAIL redir_first_pops got=%h,%h expected=00000100,00000104",
                         popped_pc[0], popped_pc[1]);
            end
        end
        for (int i = 0; i < popped_pc.size(); i++) begin
            checks++;
            if (popped_pc[i] < 32'h100 || popped_instr[i] !== instr_of(popped_pc[i])) begin
                failures++;
                $display("FAIL redir_stale i=%0d got pc=%h instr=%h expected pc>=00000100 instr=%h",
                         i, popped_pc[i], popped_instr[i], instr_of(popped_pc[i]));
            end
        end
    endtask

    task automatic test_redirect_coincide();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        do_reset(2);
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        sample();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
            failures++;
            $display("FAIL coin_setup got out_valid=%b out_pc=%h req_valid=%b addr=%h expected 1 0 1 c",
                     out_valid, out_pc, imem_req_valid, imem_req_addr);
        end
        step(1);
        redirect_valid = 1'b0;
        step(10);
        sample();
        checks++;
        if (fired.size() < 5 || popped_pc.size() < 3) begin
            failures++;
            $display("FAIL coin_size got fires=%0d pops=%0d expected >=5 and >=3",
                     fired.size(), popped_pc.size());
        end else begin
            checks++;
            if (fired[3] !== 32'hC || fired[4] !== 32'h40) begin
                failures++;
                $display("FAIL coin_fires got=%h,%h expected=0000000c,00000040", fired[3], fired[4]);
            end
            checks++;
            if (popped_pc[0] !== 32'h0 || popped_pc[1] !== 32'h40 || popped_pc[2] !== 32'h44) begin
                failures++;
                $display("FAIL coin_pops got=%h,%h,%h expected=00000000,00000040,00000044",
                         popped_pc[0], popped_pc[1], popped_pc[2]);
            end
        end
        for (int i = 1; i < popped_pc.size(); i++) begin
            checks++;
            if (popped_pc[i] < 32'h40 || popped_instr[i] !== instr_of(popped_pc[i])) begin
                failures++;
                $display("FAIL coin_stale i=%0d got pc=%h instr=%h expected pc>=00000040 instr=%h",
                         i, popped_pc[i], popped_instr[i], instr_of(popped_pc[i]));
            end
        end
    endtask

    task automatic test_double_redirect();
        int n_new;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        do_reset(2);
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step(1);
        redirect_pc    = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        step(10);
        sample();
        checks++;
        if (fired.size() < 5 || popped_pc.size() < 2) begin
            failures++;
            $display("FAIL dbl_size got fires=%0d pops=%0d expected >=5 and >=2",
                     fired.size(), popped_pc.size());
        end else begin
            checks++;
            if (fired[3] !== 32'h200 || fired[4] !== 32'h300) begin
                failures++;
                $display("FAIL dbl_fires got=%h,%h expected=00000200,00000300", fired[3], fired[4]);
            end
            checks++;
            if (popped_pc[0] !== 32'h300 || popped_pc[1] !== 32'h304) begin
                failures++;
                $display("FAIL dbl_pops got=%h,%h expected=00000300,00000304", popped_pc[0], popped_pc[1]);
            end
        end
        for (int i = 0; i < popped_pc.size(); i++) begin
            checks++;
            if (popped_pc[i] < 32'h300 || popped_instr[i] !== instr_of(popped_pc[i])) begin
                failures++;
                $display("FAIL dbl_stale i=%0d got pc=%h instr=%h expected pc>=00000300 instr=%h",
                         i, popped_pc[i], popped_instr[i], instr_of(popped_pc[i]));
            end
        end
        // with decode stalled the queue must fill to all four credits once drops are settled
        step(1);
        out_ready = 1'b0;
        step(10);
        sample();
        n_new = 0;
        for (int i = 0; i < fired.size(); i++) begin
            if (fired[i] >= 32'h300) n_new++;
        end
        checks++;
        if (n_new - popped_pc.size() != 4 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL dbl_credit got queued=%0d req_valid=%b expected queued=4 req_valid=0",
                     n_new - popped_pc.size(), imem_req_valid);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== AW'(32'h300 + 4 * popped_pc.size())) begin
            failures++;
            $display("FAIL dbl_head got valid=%b pc=%h expected valid=1 pc=%h",
                     out_valid, out_pc, AW'(32'h300 + 4 * popped_pc.size()));
        end
    endtask

    task automatic test_async_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        do_reset(1);
        step(3);
        imem_req_ready = 1'b0;
        step(2);
        sample();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || fired.size() != 3) begin
            failures++;
            $display("FAIL arst_setup got valid=%b pc=%h fires=%0d expected valid=1 pc=0 fires=3",
                     out_valid, out_pc, fired.size());
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate got out_valid=%b req_valid=%b expected 0 0",
                     out_valid, imem_req_valid);
        end
        checks++;
        if (out_pc !== '0) begin
            failures++;
            $display("FAIL arst_out_pc got=%h expected=0", out_pc);
        end
        step(2);
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        sample();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL arst_restart got valid=%b addr=%h expected valid=1 addr=0",
                     imem_req_valid, imem_req_addr);
        end
        step(4);
        sample();
        checks++;
        if (popped_pc.size() < 2) begin
            failures++;
            $display("FAIL arst_pops got=%0d expected at least 2", popped_pc.size());
        end else if (popped_pc[0] !== 32'h0 || popped_pc[1] !== 32'h4) begin
            failures++;
            $display("FAIL arst_pops got=%h,%h expected=00000000,00000004", popped_pc[0], popped_pc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincide();
        test_double_redirect();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
